// File: rtl/multiplexor_rr_registrado.sv
// CHANNELS-to-1 word multiplexer with a registered output and manual or round-robin selection.
// Handshake: a word moves when valid and ready are both high on a rising CLK edge; L_ACK is the ready/valid product per channel.
module multiplexor_rr_registrado #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CHANNELS*WIDTH-1:0] L,
    input  logic [CHANNELS-1:0]       L_VALID,
    output logic [CHANNELS-1:0]       L_ACK,
    input  logic [SEL_W-1:0]          SEL,
    input  logic                      MODE,
    output logic [WIDTH-1:0]          R,
    output logic [SEL_W-1:0]          R_CH,
    output logic                      R_VALID,
    input  logic                      R_READY
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr;
    logic             load;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic             man_any;
    logic             hi_any;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_any;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] ptr_next;

    assign load = !R_VALID || R_READY;

    // Round-robin: lowest valid channel at or above ptr wins, else wrap to the lowest valid channel.
    always_comb begin
        man_any = 1'b0;
        hi_any  = 1'b0;
        hi_idx  = '0;
        lo_any  = 1'b0;
        lo_idx  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (L_VALID[i]) begin
                lo_any = 1'b1;
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= ptr) begin
                    hi_any = 1'b1;
                    hi_idx = SEL_W'(i);
                end
                if (SEL == SEL_W'(i)) begin
                    man_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (MODE) begin
            grant_any = lo_any;
            grant_idx = hi_any ? hi_idx : lo_idx;
        end else begin
            grant_any = man_any;
            grant_idx = SEL;
        end
    end

    always_comb begin
        grant_word = '0;
        L_ACK      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_word = L[i*WIDTH +: WIDTH];
                L_ACK[i]   = RST_N && load && grant_any;
            end
        end
    end

    assign ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            R       <= '0;
            R_CH    <= '0;
            R_VALID <= 1'b0;
            ptr     <= '0;
        end else if (load) begin
            if (grant_any) begin
                R       <= grant_word;
                R_CH    <= grant_idx;
                R_VALID <= 1'b1;
                if (MODE) begin
                    ptr <= ptr_next;
                end
            end else begin
                R_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiplexor_rr_registrado.sv
// Bench for multiplexor_rr_registrado: a 4-channel and a 3-channel instance share stimulus
// and are checked every cycle against a queue-free behavioural model plus directed literals.
module tb_multiplexor_rr_registrado;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] l16;
    logic [3:0]  lv4;
    logic [1:0]  sel;
    logic        mode;
    logic        rdy;

    logic [3:0]  ack4;
    logic [3:0]  r4;
    logic [1:0]  ch4;
    logic        v4;
    logic [2:0]  ack3;
    logic [3:0]  r3;
    logic [1:0]  ch3;
    logic        v3;
    logic [11:0] l12;
    logic [2:0]  lv3;

    assign l12 = l16[11:0];
    assign lv3 = lv4[2:0];

    multiplexor_rr_registrado #(.WIDTH(4), .CHANNELS(4)) u4 (
        .CLK(clk), .RST_N(rst_n), .L(l16), .L_VALID(lv4), .L_ACK(ack4), .SEL(sel),
        .MODE(mode), .R(r4), .R_CH(ch4), .R_VALID(v4), .R_READY(rdy)
    );

    multiplexor_rr_registrado #(.WIDTH(4), .CHANNELS(3)) u3 (
        .CLK(clk), .RST_N(rst_n), .L(l12), .L_VALID(lv3), .L_ACK(ack3), .SEL(sel),
        .MODE(mode), .R(r3), .R_CH(ch3), .R_VALID(v3), .R_READY(rdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model state, index 0 = 4-channel instance, index 1 = 3-channel instance.
    int         nch[2] = '{4, 3};
    bit         m_valid[2] = '{0, 0};
    logic [3:0] m_r[2] = '{4'h0, 4'h0};
    int         m_ch[2] = '{0, 0};
    int         m_ptr[2] = '{0, 0};

    function automatic int pick(input int c, input int ptr, input logic [3:0] lv,
                                input logic md, input int s);
        if (!md) begin
            if (s < c && lv[s]) return s;
            return -1;
        end
        for (int k = 0; k < c; k++) begin
            int idx;
            idx = (ptr + k) % c;
            if (lv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] lv_of(input int d);
        return (d == 0) ? lv4 : {1'b0, lv4[2:0]};
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int g;
            if (!rst_n) begin
                m_valid[d] = 1'b0;
                m_r[d]     = 4'h0;
                m_ch[d]    = 0;
                m_ptr[d]   = 0;
            end else if (!m_valid[d] || rdy) begin
                g = pick(nch[d], m_ptr[d], lv_of(d), mode, int'(sel));
                if (g >= 0) begin
                    m_r[d]     = 4'((l16 >> (4 * g)) & 16'h000F);
                    m_ch[d]    = g;
                    m_valid[d] = 1'b1;
                    if (mode) m_ptr[d] = (g + 1) % nch[d];
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            int          g;
            logic [31:0] exp_ack;
            g = pick(nch[d], m_ptr[d], lv_of(d), mode, int'(sel));
            exp_ack = (rst_n && (!m_valid[d] || rdy) && g >= 0) ? (32'd1 << g) : 32'd0;
            check($sformatf("model u%0d l_ack", nch[d]), (d == 0) ? {28'd0, ack4} : {29'd0, ack3}, exp_ack);
            check($sformatf("model u%0d r_valid", nch[d]), (d == 0) ? v4 : v3, m_valid[d]);
            check($sformatf("model u%0d r", nch[d]), (d == 0) ? r4 : r3, m_r[d]);
            check($sformatf("model u%0d r_ch", nch[d]), (d == 0) ? ch4 : ch3, m_ch[d]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare_all();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rr_seq[6]  = '{0, 1, 2, 3, 0, 1};
    int skip_seq[4] = '{1, 3, 1, 3};
    int ch3_seq[4] = '{0, 1, 2, 0};

    initial begin
        rst_n = 1'b0;
        l16   = 16'h0000;
        lv4   = 4'hF;
        sel   = 2'd0;
        mode  = 1'b0;
        rdy   = 1'b0;
        #2;
        check("reset r", r4, 0);
        check("reset r_ch", ch4, 0);
        check("reset r_valid", v4, 0);
        check("reset l_ack gated", ack4, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Manual selection walks a single set bit across the channels.
        rdy = 1'b1;
        for (int s = 0; s < 4; s++) begin
            l16 = 16'h0001 << (4 * s);
            sel = s[1:0];
            #3;
            check("manual l_ack", ack4, 32'd1 << s);
            tick();
            check("manual r", r4, 4'b0001);
            check("manual r_ch", ch4, s);
            check("manual r_valid", v4, 1);
            repeat (9) tick();
        end

        // Back-pressure holds the word, then a pop and load share one edge.
        sel = 2'd2;
        l16 = 16'h0A00;
        tick();
        check("bp first load", r4, 4'hA);
        rdy = 1'b0;
        repeat (5) begin
            #3;
            check("bp l_ack held", ack4, 0);
            tick();
            check("bp r held", r4, 4'hA);
            check("bp r_valid held", v4, 1);
        end
        l16 = 16'h0B00;
        rdy = 1'b1;
        #3;
        check("bp release l_ack", ack4, 4'b0100);
        tick();
        check("bp new r", r4, 4'hB);
        check("bp no bubble", v4, 1);

        // Round-robin over four valid channels, wrapping 3 -> 0.
        mode = 1'b1;
        l16  = 16'h4321;
        lv4  = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr r_ch", ch4, rr_seq[i]);
            check("rr r", r4, rr_seq[i] + 1);
        end

        // Bring the pointer to 0 via channel 3, then skip invalid channels.
        lv4 = 4'b1000;
        tick();
        check("skip align r_ch", ch4, 3);
        lv4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("skip r_ch", ch4, skip_seq[i]);
        end
        lv4 = 4'b0000;
        tick();
        check("idle r_valid", v4, 0);
        check("idle r_ch hold", ch4, 3);
        check("idle r hold", r4, 4);

        // Three channels: select beyond range, then round-robin wrap at 2 -> 0.
        mode = 1'b0;
        sel  = 2'd1;
        lv4  = 4'hF;
        tick();
        check("c3 manual load", v3, 1);
        sel = 2'd3;
        #3;
        check("c3 sel oor l_ack", ack3, 0);
        check("c4 sel 3 l_ack", ack4, 4'b1000);
        tick();
        check("c3 sel oor r_valid", v3, 0);
        check("c3 sel oor r hold", r3, 2);
        check("c3 sel oor r_ch hold", ch3, 1);
        mode = 1'b1;
        lv4  = 4'b0100;
        tick();
        check("c3 align r_ch", ch3, 2);
        lv4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("c3 rr r_ch", ch3, ch3_seq[i]);
            check("c3 rr r", r3, ch3_seq[i] + 1);
        end

        // Asynchronous reset between edges while a word is held.
        mode = 1'b0;
        sel  = 2'd2;
        tick();
        check("pre-reset r", r4, 3);
        rdy = 1'b0;
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset r", r4, 0);
        check("async reset r_ch", ch4, 0);
        check("async reset r_valid", v4, 0);
        check("async reset l_ack", ack4, 0);
        check("async reset c3 r_valid", v3, 0);
        mode = 1'b1;
        rdy  = 1'b1;
        l16  = 16'h4321;
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset rr r_ch", ch4, 0);
        check("post-reset rr r", r4, 1);
        check("post-reset r_valid", v4, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplexor_rr_registrado.md
Name: multiplexor_rr_registrado

Overview:
Parametrised successor to the 4-to-1 conditional multiplexer. Selects one of CHANNELS input words, each WIDTH bits wide, and holds the result in an output register with a valid/ready handshake. Two selection modes: manual (SEL chooses the channel) and round-robin (rotating priority among channels with valid data). Sits between parallel producers and a single downstream consumer.

Parameters:
WIDTH, 4, bits per channel word
CHANNELS, 4, number of input channels (2..16; need not be a power of two)
SEL_W, $clog2(CHANNELS), width of SEL and R_CH (derived, do not override)

Ports:
CLK  input  1  clock; all state changes on its rising edge
RST_N  input  1  asynchronous reset, active-low
L  input  CHANNELS*WIDTH  flattened channel words; channel i = L[i*WIDTH +: WIDTH]
L_VALID  input  CHANNELS  per-channel data-valid
L_ACK  output  CHANNELS  one-hot, combinational; bit i high = channel i word taken this cycle
SEL  input  SEL_W  channel select, used in manual mode only
MODE  input  1  0 = manual, 1 = round-robin
R  output  WIDTH  registered selected word
R_CH  output  SEL_W  index of the channel that produced R
R_VALID  output  1  R/R_CH hold valid data
R_READY  input  1  downstream accepts R this cycle when R_VALID=1

Behaviour:
- Reset (RST_N=0, asynchronous): R=0, R_CH=0, R_VALID=0, round-robin pointer PTR=0. L_ACK=0 while RST_N=0. Reset asserted mid-transfer discards the held word; no acknowledgement is issued for it.
- Load condition: LOAD = (!R_VALID || R_READY). The output register accepts a new word only when LOAD=1.
- Grant (combinational):
  - MODE=0: the candidate is SEL; grant iff SEL < CHANNELS and L_VALID[SEL]=1.
  - MODE=1: scan channels PTR, PTR+1, ... wrapping modulo CHANNELS; the first one with L_VALID=1 is granted. No valid channel means no grant.
- L_ACK[g] = LOAD && grant on g; all other bits 0. At most one bit is ever set.
- On the clock edge with an ACK on channel g: R <= L[g], R_CH <= g, R_VALID <= 1. In MODE=1 only: PTR <= (g+1) mod CHANNELS, wrapping at CHANNELS-1 -> 0, including non-power-of-2 CHANNELS.
- On the clock edge with LOAD=1 and no grant: R_VALID <= 0. R and R_CH hold their last values.
- With LOAD=0 (R_VALID=1, R_READY=0): R, R_CH, R_VALID and PTR hold. L_ACK=0.
- Latency: 1 cycle from L_ACK to R_VALID. Sustained throughput: 1 word/cycle while R_READY=1.
- Simultaneous pop and load: when R_READY=1 and a grant exists in the same cycle, the old word leaves and the new word loads on the same edge. R_VALID stays 1 with no bubble.
- Mode change: MODE is sampled every cycle. PTR is kept across mode changes and is not modified in MODE=0.
- SEL out of range (SEL >= CHANNELS) in MODE=0: no grant and no ACK. This is not an error.
- Inputs are not registered. L, L_VALID, SEL and MODE must be stable before the clock edge and are used in the same cycle.

Test Plan:
1. Manual-mode equivalence: WIDTH=4, CHANNELS=4, MODE=0, R_READY=1, all L_VALID=1, L0=4'b0001 and other channels 0, SEL=0; then L1=1/SEL=1, L2=1/SEL=2, L3=1/SEL=3, each held 10 cycles -> one cycle after each step R=4'b0001, R_CH equals SEL, R_VALID=1; L_ACK equals one-hot of SEL.
2. Back-pressure: MODE=0, SEL=2, L2=4'hA valid, R_READY=0 for 5 cycles -> R=4'hA and R_VALID=1 held; L_ACK=0 after the first load. Change L2 to 4'hB and raise R_READY -> R=4'hB on the next edge with no bubble.
3. Round-robin fairness and wrap: MODE=1, all 4 channels valid with L_i=i+1, R_READY=1 -> R_CH sequence 0,1,2,3,0,1 and R sequence 1,2,3,4,1,2; PTR wraps 3->0.
4. Round-robin skip: MODE=1, L_VALID=4'b1010, PTR=0 -> grants 1,3,1,3. Drop all L_VALID -> R_VALID=0 one cycle later while R and R_CH hold.
5. Non-power-of-2 / out of range: CHANNELS=3 (SEL_W=2), MODE=0, SEL=3 -> L_ACK=0 and R_VALID falls to 0. MODE=1 with all valid -> R_CH sequence 0,1,2,0.
6. Reset mid-operation: R_VALID=1, R_READY=0, pull RST_N low between clock edges -> R=0, R_CH=0, R_VALID=0 and L_ACK=0 immediately. After release with MODE=1, the first grant starts from channel 0.
